// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared state encoding, vectors and IF_ID layout for the fetch stage
package if_stage_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } if_state_t;

  localparam logic [31:0] IF_RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] IF_IRQ_VECTOR   = 32'h8000_0004;
  localparam logic [31:0] IF_EXC_VECTOR   = 32'h8000_0008;
  localparam logic [31:0] IF_NOP_WORD     = 32'h0000_0000;

  localparam int IF_ID_INSTR_LSB = 0;
  localparam int IF_ID_INSTR_MSB = 31;
  localparam int IF_ID_PC4_LSB   = 32;
  localparam int IF_ID_PC4_MSB   = 63;

  // Builds the IF_ID word from its return-address and instruction fields.
  function automatic logic [63:0] pack_if_id(input logic [31:0] pc4, input logic [31:0] instr);
    logic [63:0] r;
    r = '0;
    r[IF_ID_PC4_MSB:IF_ID_PC4_LSB]     = pc4;
    r[IF_ID_INSTR_MSB:IF_ID_INSTR_LSB] = instr;
    return r;
  endfunction

endpackage

// File: rtl/if_redirect_mux.sv
// rtl/if_redirect_mux.sv - priority select of redirect request and target address
module if_redirect_mux
  import if_stage_pkg::*;
#(
  parameter logic [31:0] IRQ_VECTOR = IF_IRQ_VECTOR,
  parameter logic [31:0] EXC_VECTOR = IF_EXC_VECTOR
) (
  input  logic        interrupt,
  input  logic        exception,
  input  logic        jr,
  input  logic        j,
  input  logic        z,
  input  logic        write_en,
  input  logic [31:0] jr_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] branch_target,
  output logic        redirect,
  output logic [31:0] target
);

  // Traps always win; control-flow redirects only count when decode is not stalled.
  always_comb begin
    redirect = 1'b1;
    target   = IRQ_VECTOR;
    if (interrupt) begin
      target = IRQ_VECTOR;
    end else if (exception) begin
      target = EXC_VECTOR;
    end else if (write_en && jr) begin
      target = jr_target;
    end else if (write_en && j) begin
      target = jump_target;
    end else if (write_en && z) begin
      target = branch_target;
    end else begin
      redirect = 1'b0;
      target   = '0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with wait-state tolerant fetch; IF_PERF_COUNT_EN adds counters
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = IF_RESET_VECTOR,
  parameter logic [31:0] IRQ_VECTOR   = IF_IRQ_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = IF_EXC_VECTOR,
  parameter logic [31:0] NOP_WORD     = IF_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_IF_ID_Write,
  input  logic        Z,
  input  logic        J,
  input  logic        JR,
  input  logic        interrupt,
  input  logic        exception,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [63:0] IF_ID,
  output logic [31:0] PC
`ifdef IF_PERF_COUNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  if_state_t   state, state_next;
  logic [31:0] pc_q, pc_next;
  logic [63:0] if_id_q, if_id_next;
  logic [31:0] buf_word, buf_next;
  logic [31:0] drain_addr, drain_next;
  logic [31:0] pc4;
  logic [31:0] word;
  logic        word_avail;
  logic        stall;
  logic        redirect;
  logic [31:0] target;
  logic        deliver;

  if_redirect_mux #(
    .IRQ_VECTOR(IRQ_VECTOR),
    .EXC_VECTOR(EXC_VECTOR)
  ) u_redirect (
    .interrupt    (interrupt),
    .exception    (exception),
    .jr           (JR),
    .j            (J),
    .z            (Z),
    .write_en     (PC_IF_ID_Write),
    .jr_target    (jr_target),
    .jump_target  (jump_target),
    .branch_target(branch_target),
    .redirect     (redirect),
    .target       (target)
  );

  assign stall      = ~PC_IF_ID_Write;
  assign pc4        = pc_q + 32'd4;
  assign word_avail = (state == FULL) || ((state == FETCH) && imem_ready);
  assign word       = (state == FULL) ? buf_word : imem_rdata;
  assign deliver    = ~redirect && ~stall && word_avail;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Next-state: a stale outstanding request must complete (DRAIN) before a new address is issued.
  always_comb begin
    state_next = state;
    if (redirect) begin
      if ((state == FETCH || state == DRAIN) && !imem_ready) state_next = DRAIN;
      else                                                   state_next = FETCH;
    end else if (stall) begin
      case (state)
        FETCH:   if (imem_ready) state_next = FULL;
        DRAIN:   if (imem_ready) state_next = FETCH;
        FULL:    state_next = FULL;
        default: state_next = FETCH;
      endcase
    end else begin
      case (state)
        DRAIN:   state_next = imem_ready ? FETCH : DRAIN;
        default: state_next = FETCH;
      endcase
    end
  end

  // Outputs: only FULL stops requesting; DRAIN keeps presenting the abandoned address.
  always_comb begin
    imem_req  = (state != FULL);
    imem_addr = (state == DRAIN) ? drain_addr : pc_q;
  end

  // Datapath next values for PC, IF_ID, hold buffer and drain address.
  always_comb begin
    pc_next    = pc_q;
    if_id_next = if_id_q;
    buf_next   = buf_word;
    drain_next = drain_addr;
    if (redirect) begin
      pc_next    = target;
      if_id_next = pack_if_id(target + 32'd4, NOP_WORD);
      if ((state == FETCH) && !imem_ready) drain_next = pc_q;
    end else if (stall) begin
      if ((state == FETCH) && imem_ready) buf_next = imem_rdata;
    end else if (word_avail) begin
      pc_next    = pc4;
      if_id_next = pack_if_id(pc4, word);
    end else begin
      if_id_next = pack_if_id(pc4, NOP_WORD);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      if_id_q    <= pack_if_id(RESET_VECTOR + 32'd4, NOP_WORD);
      buf_word   <= '0;
      drain_addr <= '0;
    end else begin
      pc_q       <= pc_next;
      if_id_q    <= if_id_next;
      buf_word   <= buf_next;
      drain_addr <= drain_next;
    end
  end

  assign PC    = pc_q;
  assign IF_ID = if_id_q;

`ifdef IF_PERF_COUNT_EN
  // Saturating counters of delivered instructions and taken redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (deliver && (fetch_count != 32'hFFFF_FFFF)) fetch_count <= fetch_count + 32'd1;
      if (redirect && (flush_count != 32'hFFFF_FFFF)) flush_count <= flush_count + 32'd1;
    end
  end
`else
  logic unused_deliver;
  assign unused_deliver = deliver;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        PC_IF_ID_Write;
  logic        Z, J, JR, interrupt, exception;
  logic [31:0] branch_target, jump_target, jr_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [63:0] IF_ID;
  logic [31:0] PC;
`ifdef IF_PERF_COUNT_EN
  logic [31:0] fetch_count, flush_count;
`endif

  int total = 0;
  int bad   = 0;
  int wait_cfg = 0;
  int wcnt = 0;

  always #5 clk = ~clk;

  // Memory model: returns the address as data after wait_cfg wait states.
  assign imem_ready = imem_req && (wcnt == wait_cfg);
  assign imem_rdata = imem_addr;
  always @(posedge clk) begin
    if (reset || !imem_req || imem_ready) wcnt <= 0;
    else                                  wcnt <= wcnt + 1;
  end

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .PC_IF_ID_Write(PC_IF_ID_Write),
    .Z             (Z),
    .J             (J),
    .JR            (JR),
    .interrupt     (interrupt),
    .exception     (exception),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .IF_ID         (IF_ID),
    .PC            (PC)
`ifdef IF_PERF_COUNT_EN
    ,
    .fetch_count   (fetch_count),
    .flush_count   (flush_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    PC_IF_ID_Write = 1'b1;
    Z = 1'b0; J = 1'b0; JR = 1'b0; interrupt = 1'b0; exception = 1'b0;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] pc4, input logic [31:0] instr,
                              input logic [31:0] pc);
    check({tag, ".if_id"}, IF_ID, {pc4, instr});
    check({tag, ".pc"}, 64'(PC), 64'(pc));
  endtask

  initial begin
    idle();
    branch_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;
    reset = 1'b1;
    step();
    step();
    expect_state("reset", 32'h8000_0004, 32'h0, 32'h8000_0000);
    check("reset.req", 64'(imem_req), 64'd1);
    check("reset.addr", 64'(imem_addr), 64'h8000_0000);
    reset = 1'b0;

    // zero-wait streaming
    step(); expect_state("s1", 32'h8000_0004, 32'h8000_0000, 32'h8000_0004);
    check("s1.req", 64'(imem_req), 64'd1);
    step(); expect_state("s2", 32'h8000_0008, 32'h8000_0004, 32'h8000_0008);
    step(); expect_state("s3", 32'h8000_000C, 32'h8000_0008, 32'h8000_000C);
    step(); expect_state("s4", 32'h8000_0010, 32'h8000_000C, 32'h8000_0010);

    // two-cycle stall with ready high at PC 8000_0010
    PC_IF_ID_Write = 1'b0;
    step(); expect_state("st1", 32'h8000_0010, 32'h8000_000C, 32'h8000_0010);
    check("st1.req", 64'(imem_req), 64'd0);
    step(); expect_state("st2", 32'h8000_0010, 32'h8000_000C, 32'h8000_0010);
    check("st2.req", 64'(imem_req), 64'd0);
    PC_IF_ID_Write = 1'b1;
    step(); expect_state("rel", 32'h8000_0014, 32'h8000_0010, 32'h8000_0014);
    check("rel.addr", 64'(imem_addr), 64'h8000_0014);
`ifdef IF_PERF_COUNT_EN
    check("perf.fetch5", 64'(fetch_count), 64'd5);
`endif

    step(); step(); step();
    expect_state("s8", 32'h8000_0020, 32'h8000_001C, 32'h8000_0020);

    // taken branch while a 3-wait-state fetch of 8000_0020 is outstanding
    wait_cfg = 3;
    #1;
    Z = 1'b1; branch_target = 32'h8000_0100;
    step(); idle();
    expect_state("br", 32'h8000_0104, 32'h0, 32'h8000_0100);
    check("br.drain_addr", 64'(imem_addr), 64'h8000_0020);
    step();
    check("dr2.addr", 64'(imem_addr), 64'h8000_0020);
    expect_state("dr2", 32'h8000_0104, 32'h0, 32'h8000_0100);
    step();
    check("dr3.addr", 64'(imem_addr), 64'h8000_0020);
    check("dr3.req", 64'(imem_req), 64'd1);
    step();
    check("post_dr.addr", 64'(imem_addr), 64'h8000_0100);
    expect_state("post_dr", 32'h8000_0104, 32'h0, 32'h8000_0100);
    wait_cfg = 0;
    step(); expect_state("tgt", 32'h8000_0104, 32'h8000_0100, 32'h8000_0104);

    // J beats Z
    J = 1'b1; Z = 1'b1; jump_target = 32'h0040_0000; branch_target = 32'h8000_0200;
    step(); idle();
    expect_state("jz", 32'h0040_0004, 32'h0, 32'h0040_0000);
`ifdef IF_PERF_COUNT_EN
    check("perf.flush2", 64'(flush_count), 64'd2);
`endif
    step(); expect_state("j1", 32'h0040_0004, 32'h0040_0000, 32'h0040_0004);

    // stall suppresses a branch, but not an interrupt
    PC_IF_ID_Write = 1'b0; Z = 1'b1;
    step(); expect_state("stz", 32'h0040_0004, 32'h0040_0000, 32'h0040_0004);
    check("stz.req", 64'(imem_req), 64'd0);
    Z = 1'b0; interrupt = 1'b1;
    step(); expect_state("irq", 32'h8000_0008, 32'h0, 32'h8000_0004);
    check("irq.req", 64'(imem_req), 64'd1);
    idle();
    step(); expect_state("irq1", 32'h8000_0008, 32'h8000_0004, 32'h8000_0008);

    // exception beats JR; then JR wrap-around of PC+4
    exception = 1'b1; JR = 1'b1; jr_target = 32'h1234_5678;
    step(); idle();
    expect_state("exc", 32'h8000_000C, 32'h0, 32'h8000_0008);
    JR = 1'b1; jr_target = 32'hFFFF_FFFC;
    step(); idle();
    expect_state("jrw", 32'h0000_0000, 32'h0, 32'hFFFF_FFFC);
    step(); expect_state("wrap", 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000);

    // redirect into DRAIN, then reset abandons it
    wait_cfg = 3;
    #1;
    JR = 1'b1; jr_target = 32'h8000_0100;
    step(); idle();
    check("jrd.addr", 64'(imem_addr), 64'h0000_0000);
    expect_state("jrd", 32'h8000_0104, 32'h0, 32'h8000_0100);
`ifdef IF_PERF_COUNT_EN
    check("perf.fetch", 64'(fetch_count), 64'd12);
    check("perf.flush", 64'(flush_count), 64'd6);
`endif
    reset = 1'b1;
    step();
    expect_state("rst2", 32'h8000_0004, 32'h0, 32'h8000_0000);
    check("rst2.addr", 64'(imem_addr), 64'h8000_0000);
    check("rst2.req", 64'(imem_req), 64'd1);
`ifdef IF_PERF_COUNT_EN
    check("rst2.fetch", 64'(fetch_count), 64'd0);
    check("rst2.flush", 64'(flush_count), 64'd0);
`endif
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC and fetches from instruction memory over a req/ready handshake that tolerates wait states.
- Applies redirects (interrupt, exception, jr, j, taken branch) and stalls that decode reports in the same cycle.
- Produces the 64-bit IF_ID pipeline register: [31:0] instruction, [63:32] PC+4.

Parameters:
- RESET_VECTOR, 32'h8000_0000, PC after reset (supervisor, PC[31]=1)
- IRQ_VECTOR, 32'h8000_0004, PC on interrupt
- EXC_VECTOR, 32'h8000_0008, PC on exception (undefined instruction)
- NOP_WORD, 32'h0000_0000, instruction inserted as bubble (sll $0,$0,0)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- PC_IF_ID_Write  in  1  from decode; 0 = load-use stall, hold PC and IF_ID
- Z  in  1  decode: branch taken
- J  in  1  decode: j/jal
- JR  in  1  decode: jr/jalr
- interrupt  in  1  decode: take interrupt
- exception  in  1  decode: take exception
- branch_target  in  32  branch destination
- jump_target  in  32  jump destination
- jr_target  in  32  register-jump destination
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  fetched instruction
- IF_ID  out  64  pipeline register {PC+4, instruction}
- PC  out  32  address of next instruction to deliver

Behaviour:
- Reset (synchronous, active-high):
  - PC = RESET_VECTOR; state = FETCH; hold buffer empty.
  - IF_ID = {RESET_VECTOR+4, NOP_WORD}; imem_req = 1 in the first cycle after reset.
- FSM states:
  - FETCH: imem_req=1, imem_addr=PC.
  - FULL: fetched word held in a 1-entry buffer; imem_req=0.
  - DRAIN: stale request outstanding; imem_req=1, imem_addr=drain_addr.
- Handshake:
  - req and addr stay stable until imem_ready is sampled high.
  - ready may assert in the same cycle as req (zero-wait), which gives 1 instruction per cycle.
  - ready while req=0 is ignored.
- Redirect selection, priority high to low:
  - interrupt -> IRQ_VECTOR
  - exception -> EXC_VECTOR
  - JR -> jr_target
  - J -> jump_target
  - Z -> branch_target
- interrupt and exception are always honoured, including during a stall.
- JR, J and Z are honoured only when PC_IF_ID_Write=1; during a stall decode re-evaluates them next cycle.
- Per cycle, first matching case applies:
  - Redirect to target T:
    - PC<=T; IF_ID<={T+4, NOP_WORD}; buffer cleared.
    - If FETCH and ~imem_ready: drain_addr<=PC, go DRAIN; otherwise go FETCH.
    - In DRAIN: stay DRAIN until ready.
  - Stall (PC_IF_ID_Write=0, no redirect):
    - IF_ID and PC held.
    - FETCH and imem_ready: word captured into buffer, go FULL.
  - Advance, word available (FULL buffer, or FETCH and imem_ready):
    - IF_ID<={PC+4, word}; PC<=PC+4; go FETCH.
  - Advance, no word (FETCH waiting, or DRAIN):
    - IF_ID<={PC+4, NOP_WORD}; PC unchanged.
    - In DRAIN: imem_ready -> FETCH (returned data discarded).
- Bubble PC+4 field is always PC+4. This keeps decode's return address (PC+4-4) correct if an interrupt lands on a bubble.
- Arithmetic: 32-bit wrap-around on PC+4; no masking of PC[31] on any target.
- Reset during DRAIN or FULL: discards everything. Memory must tolerate an abandoned request.

Optional Feature:
- Macro IF_PERF_COUNT_EN.
- Defined: adds outputs fetch_count[31:0] (instructions delivered to IF_ID) and flush_count[31:0] (redirects taken).
  - Both clear on reset and saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - State encoding FETCH=2'd0, FULL=2'd1, DRAIN=2'd2.
  - Vector constants and NOP_WORD.
  - IF_ID field offsets (INSTR 31:0, PC4 63:32).
- One sub-module, if_redirect_mux: combinational priority select of {redirect, target}. FSM, PC and buffer stay in if_stage.

Test Plan:
- Reset, zero-wait memory returning addr as data, no stalls:
  - IF_ID sequence {8000_0004,NOP}, {8000_0004,8000_0000}, {8000_0008,8000_0004}.
  - imem_req constantly 1.
- Stall for 2 cycles while ready=1 at PC=8000_0010:
  - IF_ID holds, state FULL, imem_req=0.
  - After release, IF_ID={8000_0014, data@8000_0010} with no refetch.
- Z=1, branch_target=8000_0100 with 3-wait-state memory mid-fetch of 8000_0020:
  - DRAIN for 3 cycles, then req at 8000_0100.
  - IF_ID={8000_0104,NOP} during drain.
- J and Z together, jump_target=0040_0000, branch_target=8000_0200: PC becomes 0040_0000.
- Stall with Z=1: no redirect. Stall with interrupt=1: PC=8000_0004, IF_ID={8000_0008,NOP}.
- With IF_PERF_COUNT_EN: 5 delivered instructions plus 2 redirects -> fetch_count=5, flush_count=2.
